// File: rtl/write_resp_arbiter.sv
// Write-response arbiter: round-robin between two B-channel slaves, one held response at a time.
// Optional RESP-state timeout is compiled in with `define WRESP_TIMEOUT_EN.
module write_resp_arbiter #(
  parameter int Num_Of_Masters  = 2,
  parameter int Master_ID_Width = (Num_Of_Masters > 1) ? $clog2(Num_Of_Masters) : 1,
  parameter int Timeout_Cycles  = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       M00_AXI_bvalid,
  input  logic [1:0]                 M00_AXI_bresp,
  input  logic [Master_ID_Width-1:0] M00_AXI_bid,
  output logic                       M00_AXI_bready,
  input  logic                       M01_AXI_bvalid,
  input  logic [1:0]                 M01_AXI_bresp,
  input  logic [Master_ID_Width-1:0] M01_AXI_bid,
  output logic                       M01_AXI_bready,
  output logic                       Sel_Valid,
  output logic [Master_ID_Width-1:0] Sel_Resp_ID,
  output logic [1:0]                 Sel_Write_Resp,
  input  logic                       S00_AXI_bready,
  input  logic                       S01_AXI_bready,
  output logic                       Resp_Grant,
  output logic                       Timeout_Err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic                       rr_ptr_q, rr_ptr_d;
  logic                       sel_valid_q, sel_valid_d;
  logic [Master_ID_Width-1:0] sel_resp_id_q, sel_resp_id_d;
  logic [1:0]                 sel_write_resp_q, sel_write_resp_d;
  logic                       resp_grant_q, resp_grant_d;

  logic                       any_valid_s;
  logic                       win_idx_s;
  logic [Master_ID_Width-1:0] win_id_s;
  logic [1:0]                 win_resp_s;
  logic                       master_ready_s;
  logic                       in_idle_s;

`ifdef WRESP_TIMEOUT_EN
  localparam int CntW = ($clog2(Timeout_Cycles) > 8) ? $clog2(Timeout_Cycles) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout_Cycles - 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  assign any_valid_s = M00_AXI_bvalid | M01_AXI_bvalid;

  // Winner selection: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    win_idx_s = 1'b0;
    if (M00_AXI_bvalid && M01_AXI_bvalid) begin
      win_idx_s = rr_ptr_q;
    end else if (M01_AXI_bvalid) begin
      win_idx_s = 1'b1;
    end else begin
      win_idx_s = 1'b0;
    end
  end

  // Winner payload mux.
  always_comb begin
    win_id_s   = M00_AXI_bid;
    win_resp_s = M00_AXI_bresp;
    if (win_idx_s) begin
      win_id_s   = M01_AXI_bid;
      win_resp_s = M01_AXI_bresp;
    end else begin
      win_id_s   = M00_AXI_bid;
      win_resp_s = M00_AXI_bresp;
    end
  end

  // Destination master ready; any ID other than zero routes to S01.
  always_comb begin
    master_ready_s = 1'b0;
    if (sel_resp_id_q == {Master_ID_Width{1'b0}}) begin
      master_ready_s = S00_AXI_bready;
    end else begin
      master_ready_s = S01_AXI_bready;
    end
  end

  // Slave accept is only offered in IDLE and never while reset is asserted.
  assign in_idle_s      = ARESETN && (state_q == ST_IDLE);
  assign M00_AXI_bready = in_idle_s & any_valid_s & ~win_idx_s;
  assign M01_AXI_bready = in_idle_s & any_valid_s &  win_idx_s;

  // Next-state and holding-register update.
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    sel_valid_d      = sel_valid_q;
    sel_resp_id_d    = sel_resp_id_q;
    sel_write_resp_d = sel_write_resp_q;
    resp_grant_d     = resp_grant_q;
`ifdef WRESP_TIMEOUT_EN
    tmo_cnt_d        = tmo_cnt_q;
    timeout_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          sel_resp_id_d    = win_id_s;
          sel_write_resp_d = win_resp_s;
          resp_grant_d     = win_idx_s;
          sel_valid_d      = 1'b1;
          state_d          = ST_RESP;
`ifdef WRESP_TIMEOUT_EN
          tmo_cnt_d        = {CntW{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (master_ready_s) begin
          sel_valid_d = 1'b0;
          rr_ptr_d    = ~resp_grant_q;
          state_d     = ST_IDLE;
`ifdef WRESP_TIMEOUT_EN
        end else if (tmo_cnt_q == CntLast) begin
          // Ready in the final cycle is handled above, so this is a true drop.
          sel_valid_d   = 1'b0;
          rr_ptr_d      = ~resp_grant_q;
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d = ST_RESP;
        end
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset silently discards any held response.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= 1'b0;
      sel_valid_q      <= 1'b0;
      sel_resp_id_q    <= {Master_ID_Width{1'b0}};
      sel_write_resp_q <= 2'b00;
      resp_grant_q     <= 1'b0;
`ifdef WRESP_TIMEOUT_EN
      tmo_cnt_q        <= {CntW{1'b0}};
      timeout_err_q    <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      sel_valid_q      <= sel_valid_d;
      sel_resp_id_q    <= sel_resp_id_d;
      sel_write_resp_q <= sel_write_resp_d;
      resp_grant_q     <= resp_grant_d;
`ifdef WRESP_TIMEOUT_EN
      tmo_cnt_q        <= tmo_cnt_d;
      timeout_err_q    <= timeout_err_d;
`endif
    end
  end

  assign Sel_Valid      = sel_valid_q;
  assign Sel_Resp_ID    = sel_resp_id_q;
  assign Sel_Write_Resp = sel_write_resp_q;
  assign Resp_Grant     = resp_grant_q;
`ifdef WRESP_TIMEOUT_EN
  assign Timeout_Err    = timeout_err_q;
`else
  assign Timeout_Err    = 1'b0;
`endif

  write_resp_arbiter_chk #(
    .Master_ID_Width (Master_ID_Width),
    .Timeout_Cycles  (Timeout_Cycles)
  ) u_chk (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .m00_bready     (M00_AXI_bready),
    .m01_bready     (M01_AXI_bready),
    .sel_valid      (Sel_Valid),
    .sel_resp_id    (Sel_Resp_ID),
    .sel_write_resp (Sel_Write_Resp),
    .resp_grant     (Resp_Grant),
    .master_ready   (master_ready_s),
    .timeout_err    (Timeout_Err)
  );

endmodule

// Protocol invariants of the arbiter: exclusive slave accept, stable held response.
module write_resp_arbiter_chk #(
  parameter int Master_ID_Width = 1,
  parameter int Timeout_Cycles  = 16
) (
  input logic                       ACLK,
  input logic                       ARESETN,
  input logic                       m00_bready,
  input logic                       m01_bready,
  input logic                       sel_valid,
  input logic [Master_ID_Width-1:0] sel_resp_id,
  input logic [1:0]                 sel_write_resp,
  input logic                       resp_grant,
  input logic                       master_ready,
  input logic                       timeout_err
);

  a_cfg_timeout: assert property (@(posedge ACLK) Timeout_Cycles >= 1);

  a_bready_excl: assert property (@(posedge ACLK) !(m00_bready && m01_bready));

  a_no_accept_while_held: assert property (@(posedge ACLK) disable iff (!ARESETN)
    sel_valid |-> (!m00_bready && !m01_bready));

  a_held_stable: assert property (@(posedge ACLK) disable iff (!ARESETN)
    (sel_valid && !master_ready) |=>
      ($stable(sel_resp_id) && $stable(sel_write_resp) && $stable(resp_grant)));

  a_err_after_drop: assert property (@(posedge ACLK) disable iff (!ARESETN)
    timeout_err |-> !sel_valid);

endmodule

// File: tb/tb_write_resp_arbiter.sv
// Directed self-checking bench for write_resp_arbiter; timeout scenario follows WRESP_TIMEOUT_EN.
module tb_write_resp_arbiter;

`ifdef WRESP_TIMEOUT_EN
  localparam int TmoCycles = 4;
`else
  localparam int TmoCycles = 16;
`endif

  logic       ACLK;
  logic       ARESETN;
  logic       M00_AXI_bvalid, M01_AXI_bvalid;
  logic [1:0] M00_AXI_bresp, M01_AXI_bresp;
  logic [0:0] M00_AXI_bid, M01_AXI_bid;
  logic       M00_AXI_bready, M01_AXI_bready;
  logic       Sel_Valid;
  logic [0:0] Sel_Resp_ID;
  logic [1:0] Sel_Write_Resp;
  logic       S00_AXI_bready, S01_AXI_bready;
  logic       Resp_Grant;
  logic       Timeout_Err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  write_resp_arbiter #(
    .Num_Of_Masters (2),
    .Timeout_Cycles (TmoCycles)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .M00_AXI_bvalid (M00_AXI_bvalid),
    .M00_AXI_bresp  (M00_AXI_bresp),
    .M00_AXI_bid    (M00_AXI_bid),
    .M00_AXI_bready (M00_AXI_bready),
    .M01_AXI_bvalid (M01_AXI_bvalid),
    .M01_AXI_bresp  (M01_AXI_bresp),
    .M01_AXI_bid    (M01_AXI_bid),
    .M01_AXI_bready (M01_AXI_bready),
    .Sel_Valid      (Sel_Valid),
    .Sel_Resp_ID    (Sel_Resp_ID),
    .Sel_Write_Resp (Sel_Write_Resp),
    .S00_AXI_bready (S00_AXI_bready),
    .S01_AXI_bready (S01_AXI_bready),
    .Resp_Grant     (Resp_Grant),
    .Timeout_Err    (Timeout_Err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    M00_AXI_bvalid = 1'b1; M00_AXI_bid = 1'b0; M00_AXI_bresp = 2'b00;
    M01_AXI_bvalid = 1'b1; M01_AXI_bid = 1'b1; M01_AXI_bresp = 2'b00;
    S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
    tick();
    tick();
    total_cnt++; if (M00_AXI_bready !== 1'b0) $display("FAIL rst_m00_bready: got %b want 0", M00_AXI_bready); else pass_cnt++;
    total_cnt++; if (M01_AXI_bready !== 1'b0) $display("FAIL rst_m01_bready: got %b want 0", M01_AXI_bready); else pass_cnt++;
    M00_AXI_bvalid = 1'b0; M01_AXI_bvalid = 1'b0;
    ARESETN = 1'b1;
    tick();
    total_cnt++; if (Sel_Valid !== 1'b0) $display("FAIL rst_sel_valid: got %b want 0", Sel_Valid); else pass_cnt++;
    total_cnt++; if (Sel_Resp_ID !== 1'b0) $display("FAIL rst_sel_id: got %b want 0", Sel_Resp_ID); else pass_cnt++;
    total_cnt++; if (Sel_Write_Resp !== 2'b00) $display("FAIL rst_sel_resp: got %b want 00", Sel_Write_Resp); else pass_cnt++;
    total_cnt++; if (Resp_Grant !== 1'b0) $display("FAIL rst_grant: got %b want 0", Resp_Grant); else pass_cnt++;
    total_cnt++; if (Timeout_Err !== 1'b0) $display("FAIL rst_tmo_err: got %b want 0", Timeout_Err); else pass_cnt++;
    total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== 2'b00) $display("FAIL idle_breadys: got %b want 00", {M00_AXI_bready, M01_AXI_bready}); else pass_cnt++;
  endtask

  task automatic test_single();
    M00_AXI_bvalid = 1'b1; M00_AXI_bid = 1'b0; M00_AXI_bresp = 2'b00;
    S00_AXI_bready = 1'b1; S01_AXI_bready = 1'b0;
    #1;
    total_cnt++; if (M00_AXI_bready !== 1'b1) $display("FAIL single_m00_bready: got %b want 1", M00_AXI_bready); else pass_cnt++;
    total_cnt++; if (M01_AXI_bready !== 1'b0) $display("FAIL single_m01_bready: got %b want 0", M01_AXI_bready); else pass_cnt++;
    tick();
    M00_AXI_bvalid = 1'b0;
    total_cnt++; if (Sel_Valid !== 1'b1) $display("FAIL single_valid: got %b want 1", Sel_Valid); else pass_cnt++;
    total_cnt++; if (Sel_Resp_ID !== 1'b0) $display("FAIL single_id: got %b want 0", Sel_Resp_ID); else pass_cnt++;
    total_cnt++; if (Sel_Write_Resp !== 2'b00) $display("FAIL single_resp: got %b want 00", Sel_Write_Resp); else pass_cnt++;
    total_cnt++; if (Resp_Grant !== 1'b0) $display("FAIL single_grant: got %b want 0", Resp_Grant); else pass_cnt++;
    total_cnt++; if (M00_AXI_bready !== 1'b0) $display("FAIL single_resp_bready: got %b want 0", M00_AXI_bready); else pass_cnt++;
    tick();
    total_cnt++; if (Sel_Valid !== 1'b0) $display("FAIL single_done: got %b want 0", Sel_Valid); else pass_cnt++;
  endtask

  task automatic test_route_by_id();
    // rr_ptr is now 1; M01 alone still wins because it is the only requester.
    M01_AXI_bvalid = 1'b1; M01_AXI_bid = 1'b1; M01_AXI_bresp = 2'b01;
    S00_AXI_bready = 1'b1; S01_AXI_bready = 1'b0;
    #1;
    total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== 2'b01) $display("FAIL route_breadys: got %b want 01", {M00_AXI_bready, M01_AXI_bready}); else pass_cnt++;
    tick();
    M01_AXI_bvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (Sel_Valid !== 1'b1) $display("FAIL route_hold_valid[%0d]: got %b want 1", i, Sel_Valid); else pass_cnt++;
      total_cnt++; if ({Resp_Grant, Sel_Resp_ID, Sel_Write_Resp} !== 4'b1101) $display("FAIL route_hold_data[%0d]: got %b want 1101", i, {Resp_Grant, Sel_Resp_ID, Sel_Write_Resp}); else pass_cnt++;
      tick();
    end
    S01_AXI_bready = 1'b1;
    tick();
    total_cnt++; if (Sel_Valid !== 1'b0) $display("FAIL route_done: got %b want 0", Sel_Valid); else pass_cnt++;
    total_cnt++; if ({Resp_Grant, Sel_Resp_ID, Sel_Write_Resp} !== 4'b1101) $display("FAIL route_after_hold: got %b want 1101", {Resp_Grant, Sel_Resp_ID, Sel_Write_Resp}); else pass_cnt++;
    total_cnt++; if (Timeout_Err !== 1'b0) $display("FAIL route_no_tmo: got %b want 0", Timeout_Err); else pass_cnt++;
    S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic       exp_g;
    logic [1:0] exp_r;
    // rr_ptr is 0 after the M01 completion, so M00 goes first.
    M00_AXI_bvalid = 1'b1; M00_AXI_bid = 1'b0; M00_AXI_bresp = 2'b00;
    M01_AXI_bvalid = 1'b1; M01_AXI_bid = 1'b1; M01_AXI_bresp = 2'b11;
    S00_AXI_bready = 1'b1; S01_AXI_bready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 1'b1 : 1'b0;
      exp_r = exp_g ? 2'b11 : 2'b00;
      #1;
      total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== {~exp_g, exp_g}) $display("FAIL rr_idle_breadys[%0d]: got %b want %b", k, {M00_AXI_bready, M01_AXI_bready}, {~exp_g, exp_g}); else pass_cnt++;
      tick();
      total_cnt++; if (Resp_Grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b want %b", k, Resp_Grant, exp_g); else pass_cnt++;
      total_cnt++; if ({Sel_Valid, Sel_Resp_ID, Sel_Write_Resp} !== {1'b1, exp_g, exp_r}) $display("FAIL rr_held[%0d]: got %b want %b", k, {Sel_Valid, Sel_Resp_ID, Sel_Write_Resp}, {1'b1, exp_g, exp_r}); else pass_cnt++;
      total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== 2'b00) $display("FAIL rr_resp_breadys[%0d]: got %b want 00", k, {M00_AXI_bready, M01_AXI_bready}); else pass_cnt++;
      tick();
      total_cnt++; if (Sel_Valid !== 1'b0) $display("FAIL rr_done[%0d]: got %b want 0", k, Sel_Valid); else pass_cnt++;
    end
    M00_AXI_bvalid = 1'b0; M01_AXI_bvalid = 1'b0;
    S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // First completion leaves rr_ptr at 1, so a reset must be what brings it back to 0.
    M00_AXI_bvalid = 1'b1; M00_AXI_bid = 1'b0; M00_AXI_bresp = 2'b00;
    S00_AXI_bready = 1'b1;
    tick();
    tick();
    S00_AXI_bready = 1'b0;
    tick();
    total_cnt++; if (Sel_Valid !== 1'b1) $display("FAIL mid_enter_resp: got %b want 1", Sel_Valid); else pass_cnt++;
    M01_AXI_bvalid = 1'b1; M01_AXI_bid = 1'b1; M01_AXI_bresp = 2'b00;
    ARESETN = 1'b0;
    tick();
    total_cnt++; if (Sel_Valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", Sel_Valid); else pass_cnt++;
    total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== 2'b00) $display("FAIL mid_rst_breadys: got %b want 00", {M00_AXI_bready, M01_AXI_bready}); else pass_cnt++;
    ARESETN = 1'b1;
    #1;
    total_cnt++; if ({M00_AXI_bready, M01_AXI_bready} !== 2'b10) $display("FAIL mid_rr_cleared: got %b want 10", {M00_AXI_bready, M01_AXI_bready}); else pass_cnt++;
    S00_AXI_bready = 1'b1;
    tick();
    M00_AXI_bvalid = 1'b0; M01_AXI_bvalid = 1'b0;
    total_cnt++; if ({Sel_Valid, Resp_Grant} !== 2'b10) $display("FAIL mid_post_grant: got %b want 10", {Sel_Valid, Resp_Grant}); else pass_cnt++;
    tick();
    S00_AXI_bready = 1'b0;
  endtask

  task automatic test_timeout();
    // Held ID 1 with only master 0 ready: the wrong master's ready must be ignored.
    M01_AXI_bvalid = 1'b1; M01_AXI_bid = 1'b1; M01_AXI_bresp = 2'b10;
    S00_AXI_bready = 1'b1; S01_AXI_bready = 1'b0;
    tick();
    M01_AXI_bvalid = 1'b0;
`ifdef WRESP_TIMEOUT_EN
    for (int i = 0; i < TmoCycles; i++) begin
      total_cnt++; if ({Sel_Valid, Timeout_Err} !== 2'b10) $display("FAIL tmo_wait[%0d]: got %b want 10", i, {Sel_Valid, Timeout_Err}); else pass_cnt++;
      tick();
    end
    total_cnt++; if ({Sel_Valid, Timeout_Err} !== 2'b01) $display("FAIL tmo_drop: got %b want 01", {Sel_Valid, Timeout_Err}); else pass_cnt++;
    total_cnt++; if ({Sel_Resp_ID, Sel_Write_Resp} !== 3'b110) $display("FAIL tmo_data_kept: got %b want 110", {Sel_Resp_ID, Sel_Write_Resp}); else pass_cnt++;
    tick();
    total_cnt++; if ({Sel_Valid, Timeout_Err} !== 2'b00) $display("FAIL tmo_pulse_end: got %b want 00", {Sel_Valid, Timeout_Err}); else pass_cnt++;
`else
    for (int i = 0; i < 22; i++) begin
      total_cnt++; if ({Sel_Valid, Timeout_Err} !== 2'b10) $display("FAIL hold_wait[%0d]: got %b want 10", i, {Sel_Valid, Timeout_Err}); else pass_cnt++;
      total_cnt++; if ({Sel_Resp_ID, Sel_Write_Resp} !== 3'b110) $display("FAIL hold_data[%0d]: got %b want 110", i, {Sel_Resp_ID, Sel_Write_Resp}); else pass_cnt++;
      tick();
    end
    S01_AXI_bready = 1'b1;
    tick();
    total_cnt++; if ({Sel_Valid, Timeout_Err} !== 2'b00) $display("FAIL hold_done: got %b want 00", {Sel_Valid, Timeout_Err}); else pass_cnt++;
`endif
    S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0;
    M00_AXI_bvalid = 1'b0; M00_AXI_bresp = 2'b00; M00_AXI_bid = 1'b0;
    M01_AXI_bvalid = 1'b0; M01_AXI_bresp = 2'b00; M01_AXI_bid = 1'b0;
    S00_AXI_bready = 1'b0; S01_AXI_bready = 1'b0;
    test_reset();
    test_single();
    test_route_by_id();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
